internal_flash_reader: RTL and testbench

- Avalon-MM read master that drives the data port of the MAX10 on-chip flash (UFM) wrapper on the 10M04 CPU socket board.
- Turns single-byte host reads (CPU-socket ROM fetches) into aligned burst reads of the 32-bit flash data port.
- Keeps one line of BURST_LEN words, so sequential ROM fetches hit without touching flash.
- Does not use the CSR port; erase and program are outside this block.

---
 rtl/internal_flash_reader_if.sv | 46 ++++
 rtl/internal_flash_reader.sv | 169 ++++++++++++++++
 tb/tb_internal_flash_reader.sv | 250 +++++++++++++++++++++++++
 3 files changed

// File: rtl/internal_flash_reader_if.sv
// Port bundles for the flash reader: the CPU-socket host side and the Avalon-MM
// data port of the on-chip flash wrapper.

// Host side: host_rd is a one-cycle strobe taken only while host_busy is low;
// host_rvalid pulses once per accepted strobe with host_rdata valid in that cycle.
interface flash_host_if #(
    parameter int ADDR_W = 14
);
    logic              host_rd;
    logic [ADDR_W-1:0] host_addr;
    logic              invalidate;
    logic              host_busy;
    logic              host_rvalid;
    logic [7:0]        host_rdata;

    modport master (
        output host_rd, host_addr, invalidate,
        input  host_busy, host_rvalid, host_rdata
    );
    modport slave (
        input  host_rd, host_addr, invalidate,
        output host_busy, host_rvalid, host_rdata
    );
endinterface

// Flash side: a read request is accepted on the first edge where read=1 and
// waitrequest=0; the slave then returns burstcount beats, one per readdatavalid.
interface flash_avmm_if #(
    parameter int WORD_W = 12
);
    logic [WORD_W-1:0] avmm_data_addr;
    logic              avmm_data_read;
    logic [3:0]        avmm_data_burstcount;
    logic              avmm_data_waitrequest;
    logic [31:0]       avmm_data_readdata;
    logic              avmm_data_readdatavalid;

    modport master (
        output avmm_data_addr, avmm_data_read, avmm_data_burstcount,
        input  avmm_data_waitrequest, avmm_data_readdata, avmm_data_readdatavalid
    );
    modport slave (
        input  avmm_data_addr, avmm_data_read, avmm_data_burstcount,
        output avmm_data_waitrequest, avmm_data_readdata, avmm_data_readdatavalid
    );
endinterface

// File: rtl/internal_flash_reader.sv
// Byte reader for the MAX10 UFM data port: single-byte host reads are served
// from a one-line buffer that is refilled by aligned Avalon-MM bursts.
module internal_flash_reader #(
    parameter int BURST_LEN = 4,
    parameter int ADDR_W    = 14
) (
    input  logic               clock,
    input  logic               reset_n,
    flash_host_if.slave        host,
    flash_avmm_if.master       avmm,
    output logic [1:0]         dbg_state
);
    localparam int WORD_W = ADDR_W - 2;
    localparam int IDX_W  = (BURST_LEN > 1) ? $clog2(BURST_LEN) : 1;
    localparam logic [WORD_W-1:0] OFF_MASK = WORD_W'(BURST_LEN - 1);

    typedef enum logic [1:0] {IDLE, ISSUE, FILL, RESPOND} state_t;

    state_t            state_q, state_d;
    logic              busy_q, busy_d;
    logic              rvalid_q, rvalid_d;
    logic              read_q, read_d;
    logic              valid_q, valid_d;
    logic              inv_pend_q, inv_pend_d;
    logic [7:0]        rdata_q, rdata_d;
    logic [WORD_W-1:0] avmm_addr_q, avmm_addr_d;
    logic [WORD_W-1:0] tag_q, tag_d;
    logic [ADDR_W-1:0] req_addr_q, req_addr_d;
    logic [3:0]        beat_q, beat_d;
    logic [31:0]       buf_q [BURST_LEN];
    logic [31:0]       buf_d [BURST_LEN];

    logic [WORD_W-1:0] host_word, host_tag, req_word;
    logic [IDX_W-1:0]  host_off, req_off, beat_idx;
    logic              hit;

    function automatic logic [7:0] lane_byte(input logic [31:0] w, input logic [1:0] lane);
        logic [7:0] b;
        case (lane)
            2'd0:    b = w[7:0];
            2'd1:    b = w[15:8];
            2'd2:    b = w[23:16];
            default: b = w[31:24];
        endcase
        return b;
    endfunction

    assign host_word = host.host_addr[ADDR_W-1:2];
    assign host_tag  = host_word & ~OFF_MASK;
    assign host_off  = IDX_W'(host_word & OFF_MASK);
    assign req_word  = req_addr_q[ADDR_W-1:2];
    assign req_off   = IDX_W'(req_word & OFF_MASK);
    assign beat_idx  = IDX_W'(beat_q);
    assign hit       = valid_q && (tag_q == host_tag);

    always_comb begin
        state_d     = state_q;
        busy_d      = busy_q;
        rvalid_d    = rvalid_q;
        read_d      = read_q;
        valid_d     = valid_q;
        inv_pend_d  = inv_pend_q;
        rdata_d     = rdata_q;
        avmm_addr_d = avmm_addr_q;
        tag_d       = tag_q;
        req_addr_d  = req_addr_q;
        beat_d      = beat_q;
        buf_d       = buf_q;

        case (state_q)
            IDLE: begin
                if (host.host_rd) begin
                    // A coincident invalidate turns a would-be hit into a refill.
                    if (hit && !host.invalidate) begin
                        rdata_d  = lane_byte(buf_q[host_off], host.host_addr[1:0]);
                        rvalid_d = 1'b1;
                        busy_d   = 1'b1;
                        state_d  = RESPOND;
                    end else begin
                        req_addr_d  = host.host_addr;
                        avmm_addr_d = host_tag;
                        read_d      = 1'b1;
                        busy_d      = 1'b1;
                        beat_d      = '0;
                        inv_pend_d  = 1'b0;
                        state_d     = ISSUE;
                    end
                end
                if (host.invalidate || (host.host_rd && !hit)) begin
                    valid_d = 1'b0;
                end
            end

            ISSUE, FILL: begin
                if (host.invalidate) begin
                    inv_pend_d = 1'b1;
                end
                if (state_q == ISSUE && !avmm.avmm_data_waitrequest) begin
                    read_d  = 1'b0;
                    state_d = FILL;
                end
                if (avmm.avmm_data_readdatavalid) begin
                    buf_d[beat_idx] = avmm.avmm_data_readdata;
                    beat_d          = beat_q + 4'd1;
                    if (beat_q == 4'(BURST_LEN - 1)) begin
                        // The requested word may be the beat arriving right now.
                        rdata_d  = lane_byte((beat_idx == req_off) ? avmm.avmm_data_readdata
                                                                   : buf_q[req_off],
                                             req_addr_q[1:0]);
                        valid_d  = !(inv_pend_q || host.invalidate);
                        tag_d    = avmm_addr_q;
                        rvalid_d = 1'b1;
                        read_d   = 1'b0;
                        state_d  = RESPOND;
                    end
                end
            end

            default: begin
                rvalid_d = 1'b0;
                busy_d   = 1'b0;
                state_d  = IDLE;
                if (host.invalidate) begin
                    valid_d = 1'b0;
                end
            end
        endcase
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q     <= IDLE;
            busy_q      <= 1'b0;
            rvalid_q    <= 1'b0;
            read_q      <= 1'b0;
            valid_q     <= 1'b0;
            inv_pend_q  <= 1'b0;
            rdata_q     <= '0;
            avmm_addr_q <= '0;
            tag_q       <= '0;
            req_addr_q  <= '0;
            beat_q      <= '0;
            for (int i = 0; i < BURST_LEN; i++) begin
                buf_q[i] <= '0;
            end
        end else begin
            state_q     <= state_d;
            busy_q      <= busy_d;
            rvalid_q    <= rvalid_d;
            read_q      <= read_d;
            valid_q     <= valid_d;
            inv_pend_q  <= inv_pend_d;
            rdata_q     <= rdata_d;
            avmm_addr_q <= avmm_addr_d;
            tag_q       <= tag_d;
            req_addr_q  <= req_addr_d;
            beat_q      <= beat_d;
            buf_q       <= buf_d;
        end
    end

    assign host.host_busy            = busy_q;
    assign host.host_rvalid          = rvalid_q;
    assign host.host_rdata           = rdata_q;
    assign avmm.avmm_data_addr       = avmm_addr_q;
    assign avmm.avmm_data_read       = read_q;
    assign avmm.avmm_data_burstcount = 4'(BURST_LEN);
    assign dbg_state                 = state_q;
endmodule

// File: tb/tb_internal_flash_reader.sv
// Bench for internal_flash_reader: a flash slave model with configurable stall
// and latency, plus a line-cache reference model predicting hits, data and latency.
module tb_internal_flash_reader;
    localparam int B = 4;

    logic clock   = 1'b0;
    logic reset_n = 1'b0;
    logic [1:0] dbg_state;

    flash_host_if #(.ADDR_W(14)) hif ();
    flash_avmm_if #(.WORD_W(12)) aif ();

    internal_flash_reader #(.BURST_LEN(B), .ADDR_W(14)) dut (
        .clock     (clock),
        .reset_n   (reset_n),
        .host      (hif),
        .avmm      (aif),
        .dbg_state (dbg_state)
    );

    always #5 clock = ~clock;

    int tests = 0;
    int fails = 0;

    logic [31:0] mem [4096];
    logic [11:0] burst_q [$];
    int stall_cfg = 0, lat_cfg = 0;
    bit spur_req = 0;
    int stab_bad = 0, bc_bad = 0;
    int drv_beat = -1;

    bit          m_valid = 0;
    logic [11:0] m_tag   = '0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Flash slave: stalls a new request for stall_cfg cycles, then returns B beats
    // starting lat_cfg cycles after acceptance.
    initial begin : flash_slave
        bit          read_seen, accept_pend, in_burst;
        int          stall_left, lat_left, beat_i;
        logic [11:0] acc_addr, b_addr, seen_addr;
        read_seen = 0; accept_pend = 0; in_burst = 0;
        stall_left = 0; lat_left = 0; beat_i = 0;
        acc_addr = '0; b_addr = '0; seen_addr = '0;
        aif.avmm_data_waitrequest   = 1'b0;
        aif.avmm_data_readdatavalid = 1'b0;
        aif.avmm_data_readdata      = '0;
        forever begin
            @(posedge clock); #1;
            aif.avmm_data_readdatavalid = 1'b0;
            drv_beat = -1;
            if (!reset_n) begin
                read_seen = 0; accept_pend = 0; in_burst = 0;
                aif.avmm_data_waitrequest = 1'b0;
                continue;
            end
            if (accept_pend) begin
                accept_pend = 0; in_burst = 1; beat_i = 0;
                lat_left = lat_cfg; b_addr = acc_addr;
            end
            if (in_burst) begin
                if (lat_left > 0) lat_left--;
                else begin
                    aif.avmm_data_readdatavalid = 1'b1;
                    aif.avmm_data_readdata      = mem[b_addr + 12'(beat_i)];
                    drv_beat = beat_i;
                    beat_i++;
                    if (beat_i == B) in_burst = 0;
                end
            end else if (spur_req) begin
                spur_req = 0;
                aif.avmm_data_readdatavalid = 1'b1;
                aif.avmm_data_readdata      = $urandom;
            end
            if (aif.avmm_data_read) begin
                if (!read_seen) begin
                    read_seen = 1; stall_left = stall_cfg; seen_addr = aif.avmm_data_addr;
                end else if (aif.avmm_data_addr != seen_addr) stab_bad++;
                if (aif.avmm_data_burstcount != 4'(B)) bc_bad++;
                if (stall_left > 0) begin
                    aif.avmm_data_waitrequest = 1'b1;
                    stall_left--;
                end else begin
                    aif.avmm_data_waitrequest = 1'b0;
                    accept_pend = 1; acc_addr = aif.avmm_data_addr; read_seen = 0;
                    burst_q.push_back(aif.avmm_data_addr);
                end
            end else begin
                if (read_seen) stab_bad++;
                read_seen = 0;
                aif.avmm_data_waitrequest = 1'b0;
            end
        end
    end

    // One host read: predicts hit/miss, byte and latency from the line model.
    task automatic do_read(input logic [13:0] addr, input bit inv_strobe,
                           input int inv_at, input bit noisy);
        logic [11:0] word, tag;
        logic [7:0]  exp_b;
        bit          exp_hit, done, inv_fill;
        int          exp_lat, n, rv_cnt, nb0;
        word     = addr[13:2];
        tag      = word & ~12'(B - 1);
        exp_hit  = m_valid && (m_tag == tag) && !inv_strobe;
        exp_b    = 8'(mem[word] >> (8 * addr[1:0]));
        exp_lat  = exp_hit ? 1 : 2 + stall_cfg + lat_cfg + B;
        inv_fill = !exp_hit && inv_at >= 1 && inv_at < exp_lat;
        nb0      = burst_q.size();
        hif.host_rd = 1'b1; hif.host_addr = addr; hif.invalidate = inv_strobe;
        n = 0; done = 0; rv_cnt = 0;
        while (!done && n < 200) begin
            @(posedge clock); #1; n++;
            hif.host_rd = 1'b0; hif.invalidate = 1'b0;
            if (!exp_hit && n == inv_at) hif.invalidate = 1'b1;
            if (hif.host_rvalid) begin
                done = 1;
                check("rvalid_latency", n, exp_lat);
                check("rdata", hif.host_rdata, exp_b);
                check("busy_at_rvalid", hif.host_busy, 1);
            end else begin
                check("busy_while_pending", hif.host_busy, 1);
            end
            if (noisy) begin hif.host_rd = 1'b1; hif.host_addr = 14'($urandom); end
        end
        check("rvalid_seen", done, 1);
        for (int k = 0; k < 3; k++) begin
            @(posedge clock); #1;
            hif.host_rd = 1'b0; hif.invalidate = 1'b0;
            if (k == 0) check("busy_after_rvalid", hif.host_busy, 0);
            rv_cnt += int'(hif.host_rvalid);
        end
        check("extra_rvalid", rv_cnt, 0);
        check("bursts_issued", burst_q.size() - nb0, exp_hit ? 0 : 1);
        if (!exp_hit && burst_q.size() > nb0) check("burst_addr", burst_q[$], tag);
        if (!exp_hit) begin m_valid = !inv_fill; m_tag = tag; end
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_busy"},   hif.host_busy, 0);
        check({tag, "_rvalid"}, hif.host_rvalid, 0);
        check({tag, "_rdata"},  hif.host_rdata, 0);
        check({tag, "_read"},   aif.avmm_data_read, 0);
        check({tag, "_addr"},   aif.avmm_data_addr, 0);
    endtask

    initial begin : watchdog
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin : main
        int n, rv;
        int inv_at;
        bit inv_s;
        hif.host_rd = 1'b0; hif.host_addr = '0; hif.invalidate = 1'b0;
        for (int i = 0; i < 4096; i++) mem[i] = $urandom;
        mem[0] = 32'h4433_2211; mem[1] = 32'h8877_6655;
        mem[2] = 32'hCCBB_AA99; mem[3] = 32'h00FF_EEDD;

        reset_n = 1'b0;
        repeat (3) @(posedge clock);
        #1;
        check_reset_outputs("reset");
        check("reset_state", dbg_state, 0);
        reset_n = 1'b1;
        @(posedge clock); #1;

        // First miss on line 0, then hits within it.
        do_read(14'h0005, 0, 0, 0);
        check("rdata_0x66", hif.host_rdata, 8'h66);
        do_read(14'h0006, 0, 0, 0);
        do_read(14'h0008, 0, 0, 0);
        do_read(14'h000F, 0, 0, 0);

        // Stalled acceptance.
        stall_cfg = 5;
        do_read(14'h0040, 0, 0, 0);
        stall_cfg = 0;
        check("stall_stability", stab_bad, 0);

        // Invalidate during fill, then same line misses again.
        do_read(14'h0100, 0, 3, 0);
        do_read(14'h0101, 0, 0, 0);

        // Strobes while busy and in the respond cycle are ignored.
        do_read(14'h0102, 0, 0, 1);
        do_read(14'h0200, 0, 0, 1);

        // Spurious beat in idle must not disturb the line.
        spur_req = 1;
        repeat (3) @(posedge clock);
        #1;
        do_read(14'h0201, 0, 0, 0);

        // Invalidate in idle, then invalidate coincident with a hit strobe.
        hif.invalidate = 1'b1;
        @(posedge clock); #1;
        hif.invalidate = 1'b0;
        m_valid = 0;
        do_read(14'h0202, 0, 0, 0);
        do_read(14'h0203, 1, 0, 0);

        // Reset in the middle of a burst.
        hif.host_rd = 1'b1; hif.host_addr = 14'h0300;
        @(posedge clock); #1;
        hif.host_rd = 1'b0;
        n = 0;
        while (drv_beat != 2 && n < 50) begin
            @(posedge clock); #2; n++;
        end
        check("beat2_reached", drv_beat, 2);
        reset_n = 1'b0;
        #1;
        check_reset_outputs("midburst_reset");
        rv = 0;
        repeat (3) begin
            @(posedge clock); #1;
            rv += int'(hif.host_rvalid);
        end
        check("no_rvalid_in_reset", rv, 0);
        reset_n = 1'b1;
        m_valid = 0;
        @(posedge clock); #1;
        do_read(14'h0300, 0, 0, 0);

        // Randomized traffic over a small address window to mix hits and misses.
        for (int it = 0; it < 40; it++) begin
            stall_cfg = $urandom_range(0, 3);
            lat_cfg   = $urandom_range(0, 3);
            inv_s     = ($urandom_range(0, 7) == 0);
            inv_at    = ($urandom_range(0, 4) == 0) ? $urandom_range(1, 2) : 0;
            do_read(14'($urandom_range(0, 14'h7F)), inv_s, inv_at, $urandom_range(0, 1) == 1);
        end
        check("burstcount_const", bc_bad, 0);
        check("addr_read_stable", stab_bad, 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
